branch_merger: RTL and testbench

Collects completed instruction results from the `N_INSTR_BRANCHES` execution branches and merges them back into a single valid/ready stream toward the commit and writeback stage. It is the return-path counterpart to the dispatch router that fans instructions out to the branches. Each branch offers one result at a time; the merger grants one branch per cycle and registers the winner into a one-entry output stage.

---
 rtl/branch_merger_pkg.sv | 17 +
 rtl/branch_merger_rr_arbiter.sv | 41 ++++
 rtl/branch_merger.sv | 111 +++++++++++
 tb/tb_branch_merger.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_merger_pkg.sv
// rtl/branch_merger_pkg.sv - shared widths and index helper for branch_merger
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

package branch_merger_pkg;

  localparam int N_INSTR_BRANCHES = `N_INSTR_BRANCHES;
  localparam int COMMIT_ID_W      = 9;
  localparam int DEST_W           = 4;
  localparam int RES_ADDR_W       = 8;

  function automatic int branch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/branch_merger_rr_arbiter.sv
// rtl/branch_merger_rr_arbiter.sv - round-robin grant over a request vector, owns rr_ptr
module rr_arbiter
  import branch_merger_pkg::*;
#(
  parameter  int n  = 4,
  localparam int iw = branch_idx_w(n)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-1:0]  req,
  input  logic          advance,
  output logic [n-1:0]  grant,
  output logic [iw-1:0] grant_idx
);

  logic [iw-1:0] rr_ptr;
  logic          found;

  // First asserted request at or after rr_ptr, wrapping to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % n]) begin
        found                         = 1'b1;
        grant[(int'(rr_ptr) + k) % n] = 1'b1;
        grant_idx                     = iw'((int'(rr_ptr) + k) % n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_idx) == n - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/branch_merger.sv
// rtl/branch_merger.sv - merges branch results into one registered valid/ready stream
// Optional in-order commit gating: BRANCH_MERGER_IN_ORDER_EN
module branch_merger
  import branch_merger_pkg::*;
#(
  parameter  int data_width = 16,
  parameter  int n_blocks   = 256,
  parameter  int n_branches = N_INSTR_BRANCHES,
  localparam int bw         = $clog2(n_blocks),
  localparam int iw         = branch_idx_w(n_branches)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [n_branches-1:0]               in_valid,
  output logic [n_branches-1:0]               in_ready,
  input  logic [n_branches*bw-1:0]            block_in,
  input  logic [n_branches*DEST_W-1:0]        dest_in,
  input  logic [n_branches*data_width-1:0]    result_in,
  input  logic [n_branches*2*data_width-1:0]  accumulator_in,
  input  logic [n_branches*RES_ADDR_W-1:0]    res_addr_in,
  input  logic [n_branches*COMMIT_ID_W-1:0]   commit_id_in,
  input  logic [n_branches-1:0]               commit_flag_in,
  input  logic [n_branches-1:0]               writes_external_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [bw-1:0]                       block_out,
  output logic [DEST_W-1:0]                   dest_out,
  output logic [data_width-1:0]               result_out,
  output logic [2*data_width-1:0]             accumulator_out,
  output logic [RES_ADDR_W-1:0]               res_addr_out,
  output logic [COMMIT_ID_W-1:0]              commit_id_out,
  output logic                                commit_flag_out,
  output logic                                writes_external_out,
  output logic [iw-1:0]                       out_branch
);

  logic                  slot_free;
  logic                  take;
  logic [n_branches-1:0] req;
  logic [n_branches-1:0] grant;
  logic [iw-1:0]         grant_idx;

  assign slot_free = ~out_valid | out_ready;

`ifdef BRANCH_MERGER_IN_ORDER_EN
  logic [COMMIT_ID_W-1:0] expected_id;
  logic [n_branches-1:0]  id_match;

  // Only the branch holding the next commit id may compete.
  always_comb begin
    id_match = '0;
    for (int i = 0; i < n_branches; i++) begin
      id_match[i] = (commit_id_in[i*COMMIT_ID_W +: COMMIT_ID_W] == expected_id);
    end
  end

  assign req = in_valid & id_match;
`else
  assign req = in_valid;
`endif

  assign in_ready = {n_branches{reset & enable & slot_free}} & grant;
  assign take     = |(in_valid & in_ready);

  rr_arbiter #(.n(n_branches)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid           <= 1'b0;
      block_out           <= '0;
      dest_out            <= '0;
      result_out          <= '0;
      accumulator_out     <= '0;
      res_addr_out        <= '0;
      commit_id_out       <= '0;
      commit_flag_out     <= 1'b0;
      writes_external_out <= 1'b0;
      out_branch          <= '0;
`ifdef BRANCH_MERGER_IN_ORDER_EN
      expected_id         <= '0;
`endif
    end else if (enable) begin
      if (take) begin
        out_valid           <= 1'b1;
        block_out           <= block_in[grant_idx*bw +: bw];
        dest_out            <= dest_in[grant_idx*DEST_W +: DEST_W];
        result_out          <= result_in[grant_idx*data_width +: data_width];
        accumulator_out     <= accumulator_in[grant_idx*2*data_width +: 2*data_width];
        res_addr_out        <= res_addr_in[grant_idx*RES_ADDR_W +: RES_ADDR_W];
        commit_id_out       <= commit_id_in[grant_idx*COMMIT_ID_W +: COMMIT_ID_W];
        commit_flag_out     <= commit_flag_in[grant_idx];
        writes_external_out <= writes_external_in[grant_idx];
        out_branch          <= grant_idx;
`ifdef BRANCH_MERGER_IN_ORDER_EN
        expected_id         <= expected_id + 1'b1;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_merger.sv
// tb/tb_branch_merger.sv - scoreboard bench for branch_merger (in-order cases need BRANCH_MERGER_IN_ORDER_EN)
module tb_branch_merger;
  import branch_merger_pkg::*;

  localparam int NB = 4;
  localparam int DW = 16;
  localparam int BW = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0]   br;
    logic [BW-1:0]   blk;
    logic [3:0]      dest;
    logic [DW-1:0]   res;
    logic [2*DW-1:0] acc;
    logic [7:0]      addr;
    logic [8:0]      cid;
    logic            cflag;
    logic            wext;
  } item_t;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [NB-1:0]   in_valid;
  logic [NB-1:0]   in_ready;
  logic [NB*BW-1:0]   block_in;
  logic [NB*4-1:0]    dest_in;
  logic [NB*DW-1:0]   result_in;
  logic [NB*2*DW-1:0] accumulator_in;
  logic [NB*8-1:0]    res_addr_in;
  logic [NB*9-1:0]    commit_id_in;
  logic [NB-1:0]      commit_flag_in;
  logic [NB-1:0]      writes_external_in;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   block_out;
  logic [3:0]      dest_out;
  logic [DW-1:0]   result_out;
  logic [2*DW-1:0] accumulator_out;
  logic [7:0]      res_addr_out;
  logic [8:0]      commit_id_out;
  logic            commit_flag_out;
  logic            writes_external_out;
  logic [IW-1:0]   out_branch;

  item_t         src_q [NB][$];
  item_t         sb_q[$];
  logic [NB-1:0] tk;
  int            checks = 0;
  int            errors = 0;
  int            xfers  = 0;

  branch_merger #(.data_width(DW), .n_blocks(256), .n_branches(NB)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .block_in            (block_in),
    .dest_in             (dest_in),
    .result_in           (result_in),
    .accumulator_in      (accumulator_in),
    .res_addr_in         (res_addr_in),
    .commit_id_in        (commit_id_in),
    .commit_flag_in      (commit_flag_in),
    .writes_external_in  (writes_external_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .block_out           (block_out),
    .dest_out            (dest_out),
    .result_out          (result_out),
    .accumulator_out     (accumulator_out),
    .res_addr_out        (res_addr_out),
    .commit_id_out       (commit_id_out),
    .commit_flag_out     (commit_flag_out),
    .writes_external_out (writes_external_out),
    .out_branch          (out_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic item_t mk(input int br, input int cid, input logic [15:0] res);
    item_t t;
    t.br    = IW'(br);
    t.blk   = res[15:8] ^ res[7:0];
    t.dest  = res[3:0];
    t.res   = res;
    t.acc   = {~res, res};
    t.addr  = res[11:4];
    t.cid   = 9'(cid);
    t.cflag = res[0];
    t.wext  = res[1];
    return t;
  endfunction

  task automatic push_src(input int br, input int cid, input logic [15:0] res);
    src_q[br].push_back(mk(br, cid, res));
  endtask

  task automatic push_exp(input int br, input int cid, input logic [15:0] res);
    sb_q.push_back(mk(br, cid, res));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy();
    logic b;
    b = (sb_q.size() != 0) || out_valid;
    for (int i = 0; i < NB; i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy(), 1'b0);
  endtask

  // Source model: each branch holds its head item until it is taken.
  initial begin
    tk = '0;
    in_valid = '0; block_in = '0; dest_in = '0; result_in = '0; accumulator_in = '0;
    res_addr_in = '0; commit_id_in = '0; commit_flag_in = '0; writes_external_in = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        if (tk[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          item_t h;
          h = src_q[i][0];
          in_valid[i]              = 1'b1;
          block_in[i*BW +: BW]     = h.blk;
          dest_in[i*4 +: 4]        = h.dest;
          result_in[i*DW +: DW]    = h.res;
          accumulator_in[i*2*DW +: 2*DW] = h.acc;
          res_addr_in[i*8 +: 8]    = h.addr;
          commit_id_in[i*9 +: 9]   = h.cid;
          commit_flag_in[i]        = h.cflag;
          writes_external_in[i]    = h.wext;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      #1;
      tk = in_valid & in_ready;
    end
  end

  // Monitor: compare every item that will transfer on the next edge.
  initial begin
    forever begin
      item_t got;
      item_t exp;
      @(negedge clk);
      #2;
      if (reset && enable && out_valid && out_ready) begin
        xfers++;
        got = '{br: out_branch, blk: block_out, dest: dest_out, res: result_out,
                acc: accumulator_out, addr: res_addr_out, cid: commit_id_out,
                cflag: commit_flag_out, wext: writes_external_out};
        chk("sb_depth", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
          exp = sb_q.pop_front();
          chk("sb_item", got, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_result", result_out, 16'h0);
    chk("rst_acc", accumulator_out, 32'h0);
    chk("rst_branch", out_branch, 2'd0);
    chk("rst_cid", commit_id_out, 9'd0);
    tick();
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_in_ready", in_ready, 4'b0000);

    // Round robin with all branches valid: 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NB; i++) begin
        push_src(i, r*4 + i, 16'(16'h1000 + r*16 + i));
        push_exp(i, r*4 + i, 16'(16'h1000 + r*16 + i));
      end
    base = xfers;
    tick();
    chk("rr_first_branch", out_branch, 2'd0);
    chk("rr_first_valid", out_valid, 1'b1);
    chk("rr_next_grant", in_ready, 4'b0010);
    repeat (7) tick();
    chk("rr_last_branch", out_branch, 2'd3);
    chk("rr_rate_7", xfers - base, 7);
    tick();
    chk("rr_rate_8", xfers - base, 8);
    chk("rr_idle", out_valid, 1'b0);

    // Backpressure: branch 2 held, branch 1 loads on the drain edge
    out_ready = 1'b0;
    push_src(2, 8, 16'h1234); push_exp(2, 8, 16'h1234);
    tick();
    chk("bp_valid", out_valid, 1'b1);
    push_src(1, 9, 16'h0B0B); push_exp(1, 9, 16'h0B0B);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_result", result_out, 16'h1234);
      chk("bp_in_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_reload_valid", out_valid, 1'b1);
    chk("bp_reload_branch", out_branch, 2'd1);
    chk("bp_reload_result", result_out, 16'h0B0B);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // Enable low freezes everything; pointer stays at 2 so branch 3 wins first
    enable = 1'b0;
    push_src(1, 11, 16'h5555);
    push_src(3, 10, 16'h3333);
    push_exp(3, 10, 16'h3333);
    push_exp(1, 11, 16'h5555);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("en_in_ready", in_ready, 4'b0000);
      chk("en_out_valid", out_valid, 1'b0);
    end
    enable = 1'b1;
    tick();
    chk("en_first", out_branch, 2'd3);
    tick();
    chk("en_second", out_branch, 2'd1);
    chk("en_second_result", result_out, 16'h5555);
    drain("en_drain", 20);

    // Reset mid-transfer discards the held output
    out_ready = 1'b0;
    push_src(0, 12, 16'h7777);
    tick();
    chk("mrst_loaded", result_out, 16'h7777);
    reset = 1'b0;
    tick();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_result", result_out, 16'h0);
    chk("mrst_in_ready", in_ready, 4'b0000);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mrst_after", out_valid, 1'b0);

`ifdef BRANCH_MERGER_IN_ORDER_EN
    // Ids 0..4 from branch 3 leave expected_id=5 and the pointer at 0
    for (int k = 0; k < 5; k++) begin
      push_src(3, k, 16'(16'h3000 + k));
      push_exp(3, k, 16'(16'h3000 + k));
    end
    drain("io_pre_drain", 20);
    push_src(0, 6, 16'h0606);
    push_src(3, 5, 16'h0505);
    push_exp(3, 5, 16'h0505);
    push_exp(0, 6, 16'h0606);
    tick();
    chk("io_first_branch", out_branch, 2'd3);
    chk("io_first_cid", commit_id_out, 9'd5);
    tick();
    chk("io_second_branch", out_branch, 2'd0);
    chk("io_second_cid", commit_id_out, 9'd6);
    drain("io_drain", 20);

    // Run ids up to 511 on branch 2; branch 1 with id 0 must wait for the wrap
    for (int k = 7; k < 512; k++) begin
      push_src(2, k, 16'(k));
      push_exp(2, k, 16'(k));
    end
    push_src(1, 0, 16'hAAAA);
    push_exp(1, 0, 16'hAAAA);
    drain("wrap_drain", 800);
    chk("wrap_cid", commit_id_out, 9'd0);
    chk("wrap_branch", out_branch, 2'd1);
`endif

    chk("final_sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
